strait_tile_test_scheduler: RTL and testbench

- Multi-tile successor to the single-array STRAIT test top.
- Sequences MBIST, LBIST-SA and LBIST-TD test phases across NUM_TILES independent STRAIT tiles, one tile and one phase at a time.
- Times out hung tiles and triggers BISR recovery on LBIST failures.
- Accumulates a per-tile, per-phase fail/timeout map for the system controller.

---
 rtl/strait_tile_test_scheduler.sv | 258 +++++++++++++++++++++++++
 tb/tb_strait_tile_test_scheduler.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/strait_tile_test_scheduler.sv
// strait_tile_test_scheduler
//   Sweeps MBIST, LBIST-SA and LBIST-TD phases across NUM_TILES STRAIT tiles,
//   running one tile and one phase at a time. A watchdog bounds every wait.
//   An LBIST failure can trigger BISR recovery, at most once per tile per sweep.
//   Per-tile, per-phase fail and timeout maps hold until the next START or reset.
// Ports
//   clk, rst             clock, synchronous active-high reset
//   START                1-cycle sweep request, honoured only when idle
//   tile_en, phase_en    sweep selection (phase 0=MBIST 1=SA 2=TD), sampled at START
//   recovery_en          run BISR after an LBIST fail, sampled at START
//   timeout_limit        watchdog limit per wait, sampled at START
//   tile_test_done/...   per-tile test and recovery responses
//   tile_start           one-hot launch pulse to the current tile
//   tile_recovery_start  one-hot recovery request pulse
//   tile_test_mode       tile_en while busy
//   tile_bist_mode/type  phase encoding, held from LAUNCH to the next LAUNCH
//   busy, all_done       sweep status; all_done pulses once at the end of a sweep
//   fail_map/timeout_map bit tile*3+phase
//   unrecovered_map      recovery ran and failed or timed out
//   cur_tile             tile pointer, for debug
module strait_tile_test_scheduler #(
   parameter int NUM_TILES      = 4,
   parameter int TILE_IDX_WIDTH = (NUM_TILES > 1) ? $clog2(NUM_TILES) : 1,
   parameter int TIMER_WIDTH    = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      START,
   input  logic [NUM_TILES-1:0]      tile_en,
   input  logic [2:0]                phase_en,
   input  logic                      recovery_en,
   input  logic [TIMER_WIDTH-1:0]    timeout_limit,
   input  logic [NUM_TILES-1:0]      tile_test_done,
   input  logic [NUM_TILES-1:0]      tile_mbist_result,
   input  logic [NUM_TILES-1:0]      tile_lbist_result,
   input  logic [NUM_TILES-1:0]      tile_recovery_done,
   input  logic [NUM_TILES-1:0]      tile_recovery_success,
   output logic [NUM_TILES-1:0]      tile_start,
   output logic [NUM_TILES-1:0]      tile_test_mode,
   output logic                      tile_bist_mode,
   output logic                      tile_test_type,
   output logic [NUM_TILES-1:0]      tile_recovery_start,
   output logic                      busy,
   output logic                      all_done,
   output logic [3*NUM_TILES-1:0]    fail_map,
   output logic [3*NUM_TILES-1:0]    timeout_map,
   output logic [NUM_TILES-1:0]      unrecovered_map,
   output logic [TILE_IDX_WIDTH-1:0] cur_tile
);

   localparam int MAP_W = 3 * NUM_TILES;

   typedef enum logic [2:0] {
      S_IDLE, S_SELECT, S_LAUNCH, S_WAIT, S_REC_LAUNCH, S_REC_WAIT, S_NEXT, S_DONE
   } state_e;

   state_e                    state_q, state_d;
   logic [TILE_IDX_WIDTH-1:0] tile_q, tile_d;
   logic [1:0]                phase_q, phase_d;
   logic [NUM_TILES-1:0]      tile_en_q, tile_en_d;
   logic [2:0]                phase_en_q, phase_en_d;
   logic                      rec_en_q, rec_en_d;
   logic [TIMER_WIDTH-1:0]    limit_q, limit_d;
   logic [TIMER_WIDTH-1:0]    timer_q, timer_d;
   logic [MAP_W-1:0]          fail_q, fail_d;
   logic [MAP_W-1:0]          to_q, to_d;
   logic [NUM_TILES-1:0]      unrec_q, unrec_d;
   logic [NUM_TILES-1:0]      recovered_q, recovered_d;
   logic                      bist_q, bist_d;
   logic                      type_q, type_d;

   // Scan result: first enabled (tile, phase) at or after the pointer
   logic                      found;
   logic [TILE_IDX_WIDTH-1:0] sel_tile;
   logic [1:0]                sel_phase;
   int                        ptr_idx;

   logic [NUM_TILES-1:0]      cur_oh;
   logic [MAP_W-1:0]          map_bit;
   logic                      done_cur, result_cur, rdone_cur, rsucc_cur, expired;

   // Descending loop so the lowest matching index is the one that sticks
   always_comb begin
      found     = 1'b0;
      sel_tile  = '0;
      sel_phase = '0;
      ptr_idx   = 3 * int'(tile_q) + int'(phase_q);
      for (int t = NUM_TILES - 1; t >= 0; t--) begin
         for (int p = 2; p >= 0; p--) begin
            if (tile_en_q[t] && phase_en_q[p] && ((3 * t + p) >= ptr_idx)) begin
               found     = 1'b1;
               sel_tile  = TILE_IDX_WIDTH'(t);
               sel_phase = 2'(p);
            end
         end
      end
   end

   // Per-tile inputs are selected by mask so any NUM_TILES width works
   assign cur_oh     = NUM_TILES'(1) << tile_q;
   assign map_bit    = MAP_W'(1) << (3 * int'(tile_q) + int'(phase_q));
   assign done_cur   = |(tile_test_done & cur_oh);
   assign result_cur = (phase_q == 2'd0) ? |(tile_mbist_result & cur_oh)
                                         : |(tile_lbist_result & cur_oh);
   assign rdone_cur  = |(tile_recovery_done & cur_oh);
   assign rsucc_cur  = |(tile_recovery_success & cur_oh);
   assign expired    = (timer_q == limit_q);

   always_comb begin
      state_d     = state_q;
      tile_d      = tile_q;
      phase_d     = phase_q;
      tile_en_d   = tile_en_q;
      phase_en_d  = phase_en_q;
      rec_en_d    = rec_en_q;
      limit_d     = limit_q;
      timer_d     = timer_q;
      fail_d      = fail_q;
      to_d        = to_q;
      unrec_d     = unrec_q;
      recovered_d = recovered_q;
      bist_d      = bist_q;
      type_d      = type_q;

      unique case (state_q)
         S_IDLE: begin
            if (START) begin
               tile_en_d   = tile_en;
               phase_en_d  = phase_en;
               rec_en_d    = recovery_en;
               limit_d     = timeout_limit;
               fail_d      = '0;
               to_d        = '0;
               unrec_d     = '0;
               recovered_d = '0;
               tile_d      = '0;
               phase_d     = '0;
               state_d     = S_SELECT;
            end
         end
         S_SELECT: begin
            if (found) begin
               tile_d  = sel_tile;
               phase_d = sel_phase;
               // Registered here so the mode is already valid during the launch pulse
               bist_d  = (sel_phase != 2'd0);
               type_d  = (sel_phase == 2'd2);
               state_d = S_LAUNCH;
            end else begin
               state_d = S_DONE;
            end
         end
         S_LAUNCH: begin
            timer_d = '0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            timer_d = timer_q + 1'b1;
            // done takes priority over a coincident timeout
            if (done_cur) begin
               if (result_cur) begin
                  fail_d = fail_q | map_bit;
               end
               if (result_cur && (phase_q != 2'd0) && rec_en_q && !(|(recovered_q & cur_oh))) begin
                  state_d = S_REC_LAUNCH;
               end else begin
                  state_d = S_NEXT;
               end
            end else if (expired) begin
               to_d    = to_q | map_bit;
               state_d = S_NEXT;
            end
         end
         S_REC_LAUNCH: begin
            timer_d     = '0;
            recovered_d = recovered_q | cur_oh;
            state_d     = S_REC_WAIT;
         end
         S_REC_WAIT: begin
            timer_d = timer_q + 1'b1;
            if (rdone_cur) begin
               if (!rsucc_cur) begin
                  unrec_d = unrec_q | cur_oh;
               end
               state_d = S_NEXT;
            end else if (expired) begin
               unrec_d = unrec_q | cur_oh;
               state_d = S_NEXT;
            end
         end
         S_NEXT: begin
            if (phase_q == 2'd2) begin
               if (tile_q == TILE_IDX_WIDTH'(NUM_TILES - 1)) begin
                  state_d = S_DONE;
               end else begin
                  tile_d  = tile_q + 1'b1;
                  phase_d = '0;
                  state_d = S_SELECT;
               end
            end else begin
               phase_d = phase_q + 1'b1;
               state_d = S_SELECT;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         tile_q      <= '0;
         phase_q     <= '0;
         tile_en_q   <= '0;
         phase_en_q  <= '0;
         rec_en_q    <= 1'b0;
         limit_q     <= '0;
         timer_q     <= '0;
         fail_q      <= '0;
         to_q        <= '0;
         unrec_q     <= '0;
         recovered_q <= '0;
         bist_q      <= 1'b0;
         type_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         tile_q      <= tile_d;
         phase_q     <= phase_d;
         tile_en_q   <= tile_en_d;
         phase_en_q  <= phase_en_d;
         rec_en_q    <= rec_en_d;
         limit_q     <= limit_d;
         timer_q     <= timer_d;
         fail_q      <= fail_d;
         to_q        <= to_d;
         unrec_q     <= unrec_d;
         recovered_q <= recovered_d;
         bist_q      <= bist_d;
         type_q      <= type_d;
      end
   end

   assign busy                = (state_q != S_IDLE) && (state_q != S_DONE);
   assign all_done            = (state_q == S_DONE);
   assign tile_start          = (state_q == S_LAUNCH) ? cur_oh : '0;
   assign tile_recovery_start = (state_q == S_REC_LAUNCH) ? cur_oh : '0;
   assign tile_test_mode      = busy ? tile_en_q : '0;
   assign tile_bist_mode      = bist_q;
   assign tile_test_type      = type_q;
   assign fail_map            = fail_q;
   assign timeout_map         = to_q;
   assign unrecovered_map     = unrec_q;
   assign cur_tile            = tile_q;

endmodule

// File: tb/tb_strait_tile_test_scheduler.sv
module tb_strait_tile_test_scheduler;
   localparam int NT = 4;

   logic clk, rst, START, recovery_en;
   logic [NT-1:0] tile_en;
   logic [2:0] phase_en;
   logic [15:0] timeout_limit;
   logic [NT-1:0] tile_test_done, tile_mbist_result, tile_lbist_result;
   logic [NT-1:0] tile_recovery_done, tile_recovery_success;
   logic [NT-1:0] tile_start, tile_test_mode, tile_recovery_start, unrecovered_map;
   logic tile_bist_mode, tile_test_type, busy, all_done;
   logic [3*NT-1:0] fail_map, timeout_map;
   logic [1:0] cur_tile;

   strait_tile_test_scheduler #(.NUM_TILES(NT), .TILE_IDX_WIDTH(2), .TIMER_WIDTH(16)) dut (
      .clk(clk), .rst(rst), .START(START), .tile_en(tile_en), .phase_en(phase_en),
      .recovery_en(recovery_en), .timeout_limit(timeout_limit),
      .tile_test_done(tile_test_done), .tile_mbist_result(tile_mbist_result),
      .tile_lbist_result(tile_lbist_result), .tile_recovery_done(tile_recovery_done),
      .tile_recovery_success(tile_recovery_success), .tile_start(tile_start),
      .tile_test_mode(tile_test_mode), .tile_bist_mode(tile_bist_mode),
      .tile_test_type(tile_test_type), .tile_recovery_start(tile_recovery_start),
      .busy(busy), .all_done(all_done), .fail_map(fail_map), .timeout_map(timeout_map),
      .unrecovered_map(unrecovered_map), .cur_tile(cur_tile));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Tile behaviour knobs, written only by the main sequence
   int          cfg_dly  = 5;
   logic [NT-1:0]   cfg_hang  = '0;
   logic [3*NT-1:0] cfg_fail  = '0;
   logic [NT-1:0]   cfg_rsucc = '0;
   logic [NT-1:0]   cfg_rhang = '0;

   // Tile responder model: done cfg_dly cycles after tile_start, recovery done 3 cycles after request
   int cnt[NT];
   int rcnt[NT];
   logic [1:0] ph[NT];
   initial begin
      tile_test_done = '0; tile_mbist_result = '0; tile_lbist_result = '0;
      tile_recovery_done = '0; tile_recovery_success = '0;
      for (int t = 0; t < NT; t++) begin cnt[t] = 0; rcnt[t] = 0; ph[t] = 2'd0; end
   end
   always @(negedge clk) begin
      logic f;
      tile_test_done = '0;
      tile_recovery_done = '0;
      for (int t = 0; t < NT; t++) begin
         if (rst) begin
            cnt[t] = 0; rcnt[t] = 0;
         end else begin
            if (tile_start[t]) begin
               ph[t] = tile_bist_mode ? (tile_test_type ? 2'd2 : 2'd1) : 2'd0;
               cnt[t] = cfg_hang[t] ? 0 : cfg_dly;
            end else if (cnt[t] > 0) begin
               cnt[t] = cnt[t] - 1;
               if (cnt[t] == 0) begin
                  f = cfg_fail[t*3 + int'(ph[t])];
                  tile_test_done[t] = 1'b1;
                  // the unused result line carries the opposite value
                  tile_mbist_result[t] = (ph[t] == 2'd0) ? f : !f;
                  tile_lbist_result[t] = (ph[t] == 2'd0) ? !f : f;
               end
            end
            if (tile_recovery_start[t]) begin
               rcnt[t] = cfg_rhang[t] ? 0 : 3;
            end else if (rcnt[t] > 0) begin
               rcnt[t] = rcnt[t] - 1;
               if (rcnt[t] == 0) begin
                  tile_recovery_done[t] = 1'b1;
                  tile_recovery_success[t] = cfg_rsucc[t];
               end
            end
         end
      end
   end

   // Event monitor
   int n_starts = 0, n_recs = 0, n_done = 0;
   logic [3:0] slog[$];
   always @(negedge clk) begin
      n_starts += $countones(tile_start);
      n_recs   += $countones(tile_recovery_start);
      if (all_done) n_done++;
      for (int t = 0; t < NT; t++)
         if (tile_start[t]) slog.push_back({2'(t), tile_bist_mode, tile_test_type});
   end

   int checks = 0, errors = 0;
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic [3:0] ten; logic [2:0] pen; logic ren; logic [15:0] lim; int dly;
      logic [3:0] hang; logic [11:0] fail; logic [3:0] rsucc; logic [3:0] rhang;
      logic [11:0] efail; logic [11:0] eto; logic [3:0] eunrec; int estarts; int erecs;
   } vec_t;
   vec_t vt[10];

   task automatic configure(input vec_t v);
      cfg_dly = v.dly; cfg_hang = v.hang; cfg_fail = v.fail;
      cfg_rsucc = v.rsucc; cfg_rhang = v.rhang;
   endtask

   task automatic pulse_start(input vec_t v);
      tile_en = v.ten; phase_en = v.pen; recovery_en = v.ren; timeout_limit = v.lim;
      START = 1'b1;
      @(negedge clk);
      START = 1'b0;
   endtask

   task automatic wait_all_done(input string name);
      int k;
      for (k = 0; k < 3000; k++) begin
         if (all_done) break;
         @(negedge clk);
      end
      if (k == 3000) begin
         errors++;
         $display("FAIL %s: all_done not seen within 3000 cycles", name);
      end
   endtask

   task automatic run_vec(input int i);
      int s0, r0, d0;
      string nm;
      nm = $sformatf("vec%0d", i);
      configure(vt[i]);
      s0 = n_starts; r0 = n_recs; d0 = n_done;
      pulse_start(vt[i]);
      wait_all_done(nm);
      @(negedge clk); @(negedge clk);
      chk({nm, " fail_map"}, 32'(fail_map), 32'(vt[i].efail));
      chk({nm, " timeout_map"}, 32'(timeout_map), 32'(vt[i].eto));
      chk({nm, " unrecovered_map"}, 32'(unrecovered_map), 32'(vt[i].eunrec));
      chk({nm, " tile_start count"}, 32'(n_starts - s0), 32'(vt[i].estarts));
      chk({nm, " recovery_start count"}, 32'(n_recs - r0), 32'(vt[i].erecs));
      chk({nm, " all_done count"}, 32'(n_done - d0), 32'd1);
      chk({nm, " idle busy"}, 32'(busy), 32'd0);
   endtask

   task automatic wait_pulse(input string name, input bit rec);
      int k;
      for (k = 0; k < 500; k++) begin
         @(negedge clk);
         if (rec ? (tile_recovery_start != '0) : (tile_start != '0)) break;
      end
      if (k == 500) begin
         errors++;
         $display("FAIL %s: pulse not seen within 500 cycles", name);
      end
   endtask

   initial begin
      int base, d0;
      logic [3:0] e;
      //        ten      pen     ren   lim     dly hang   fail     rsucc  rhang  efail    eto      eunrec starts recs
      vt[0] = '{4'b0101, 3'b111, 1'b0, 16'd100, 5, 4'h0, 12'h000, 4'h0, 4'h0, 12'h000, 12'h000, 4'h0, 6, 0};
      vt[1] = '{4'b1111, 3'b001, 1'b0, 16'd20,  5, 4'h2, 12'h000, 4'h0, 4'h0, 12'h000, 12'h008, 4'h0, 4, 0};
      vt[2] = '{4'b0100, 3'b111, 1'b1, 16'd20,  5, 4'h0, 12'h180, 4'h0, 4'h0, 12'h180, 12'h000, 4'h4, 3, 1};
      vt[3] = '{4'b0100, 3'b111, 1'b1, 16'd20,  5, 4'h0, 12'h180, 4'h4, 4'h0, 12'h180, 12'h000, 4'h0, 3, 1};
      vt[4] = '{4'b1001, 3'b110, 1'b1, 16'd8,   5, 4'h0, 12'h802, 4'h8, 4'h1, 12'h802, 12'h000, 4'h1, 4, 2};
      vt[5] = '{4'b0011, 3'b111, 1'b0, 16'd20,  5, 4'h0, 12'h011, 4'h0, 4'h0, 12'h011, 12'h000, 4'h0, 6, 0};
      vt[6] = '{4'b0001, 3'b111, 1'b0, 16'd0,   5, 4'h0, 12'h000, 4'h0, 4'h0, 12'h000, 12'h007, 4'h0, 3, 0};
      vt[7] = '{4'b1111, 3'b000, 1'b0, 16'd20,  5, 4'h0, 12'h000, 4'h0, 4'h0, 12'h000, 12'h000, 4'h0, 0, 0};
      vt[8] = '{4'b0001, 3'b001, 1'b0, 16'd5,   6, 4'h0, 12'h001, 4'h0, 4'h0, 12'h001, 12'h000, 4'h0, 1, 0};
      vt[9] = '{4'b0001, 3'b001, 1'b0, 16'd5,   7, 4'h0, 12'h001, 4'h0, 4'h0, 12'h000, 12'h001, 4'h0, 1, 0};

      rst = 1'b1; START = 1'b0; tile_en = '0; phase_en = '0; recovery_en = 1'b0; timeout_limit = '0;
      repeat (3) @(negedge clk);
      chk("reset busy", 32'(busy), 32'd0);
      chk("reset all_done", 32'(all_done), 32'd0);
      chk("reset maps", 32'({fail_map, timeout_map, unrecovered_map}), 32'd0);
      chk("reset pulses", 32'({tile_start, tile_recovery_start, tile_test_mode}), 32'd0);
      chk("reset mode/ptr", 32'({tile_bist_mode, tile_test_type, cur_tile}), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // Launch order of the basic sweep: tiles 0,0,0,2,2,2 with MBIST, SA, TD each
      base = slog.size();
      run_vec(0);
      chk("order count", 32'(slog.size() - base), 32'd6);
      for (int j = 0; j < 6 && base + j < slog.size(); j++) begin
         e = {(j < 3) ? 2'd0 : 2'd2, (j % 3) != 0, (j % 3) == 2};
         if ((j % 3) == 0) chk($sformatf("order %0d", j), 32'(slog[base+j][3:1]), 32'(e[3:1]));
         else              chk($sformatf("order %0d", j), 32'(slog[base+j]), 32'(e));
      end

      for (int i = 1; i < 10; i++) run_vec(i);

      // Empty sweep: busy for one cycle, all_done two cycles after START
      configure(vt[0]);
      base = n_starts;
      tile_en = '0; phase_en = 3'b111; START = 1'b1;
      @(negedge clk); START = 1'b0;
      chk("empty busy c1", 32'({busy, all_done}), 32'b10);
      @(negedge clk);
      chk("empty busy c2", 32'({busy, all_done}), 32'b01);
      @(negedge clk);
      chk("empty busy c3", 32'({busy, all_done}), 32'b00);
      chk("empty no start", 32'(n_starts - base), 32'd0);

      // Timeout timing: tile 1 hangs, limit 10; sweep moves on to tile 1 SA
      cfg_hang = 4'b0010; cfg_fail = '0; cfg_dly = 5;
      tile_en = 4'b0010; phase_en = 3'b011; recovery_en = 1'b0; timeout_limit = 16'd10;
      START = 1'b1; @(negedge clk); START = 1'b0;
      wait_pulse("to launch", 1'b0);
      repeat (11) @(negedge clk);
      chk("to not yet", 32'(timeout_map[3]), 32'd0);
      @(negedge clk);
      chk("to set", 32'(timeout_map[3]), 32'd1);
      wait_pulse("to next launch", 1'b0);
      chk("to next tile", 32'({tile_start, tile_bist_mode, tile_test_type}), 32'({4'b0010, 2'b10}));
      wait_all_done("to sweep");
      @(negedge clk);
      chk("to final map", 32'(timeout_map), 32'h018);

      // START while busy is ignored
      configure(vt[0]);
      base = n_starts;
      pulse_start(vt[0]);
      repeat (4) @(negedge clk);
      tile_en = 4'b1111; START = 1'b1; @(negedge clk); START = 1'b0;
      wait_all_done("busy start");
      @(negedge clk);
      chk("busy start ignored", 32'(n_starts - base), 32'd6);

      // Reset during REC_WAIT aborts with no all_done, then a clean sweep
      cfg_dly = 5; cfg_hang = '0; cfg_fail = 12'h080; cfg_rhang = 4'b0100; cfg_rsucc = '0;
      tile_en = 4'b0100; phase_en = 3'b010; recovery_en = 1'b1; timeout_limit = 16'd50;
      START = 1'b1; @(negedge clk); START = 1'b0;
      wait_pulse("rec launch", 1'b1);
      repeat (3) @(negedge clk);
      chk("pre-reset fail_map", 32'(fail_map), 32'h080);
      d0 = n_done;
      rst = 1'b1;
      @(negedge clk);
      chk("rst busy/done", 32'({busy, all_done}), 32'd0);
      chk("rst maps", 32'({fail_map, timeout_map, unrecovered_map}), 32'd0);
      chk("rst pulses", 32'({tile_start, tile_recovery_start, tile_test_mode, cur_tile}), 32'd0);
      rst = 1'b0;
      repeat (5) @(negedge clk);
      chk("rst no all_done", 32'(n_done - d0), 32'd0);
      run_vec(5);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
